// File: rtl/mips_pkg.sv
// Shared widths, hazard-cause encoding and the load-use match for the MIPS hazard controller.
// Pure declarations: no state, no latency, no flow control.
package mips_pkg;

    localparam int REG_W       = 5;
    localparam int MDU_CNT_W   = 8;
    localparam int STALL_CNT_W = 32;

    typedef enum logic [1:0] {
        HZ_NONE    = 2'd0,
        HZ_BRANCH  = 2'd1,
        HZ_LOADUSE = 2'd2,
        HZ_MDU     = 2'd3
    } hz_cause_e;

    // r0 is hardwired to zero, so a load targeting it can never feed a consumer.
    function automatic logic load_use_hit(
        input logic             memread,
        input logic [REG_W-1:0] ex_rt,
        input logic [REG_W-1:0] id_rs,
        input logic [REG_W-1:0] id_rt,
        input logic             uses_rt
    );
        return memread && (ex_rt != '0) &&
               ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/mdu_timer.sv
// MDU occupancy timer: loads MDU_LATENCY on start, counts down to zero; busy while nonzero.
// busy rises the cycle after start and stays high for exactly MDU_LATENCY cycles; no backpressure.
module mdu_timer
    import mips_pkg::*;
#(
    parameter int MDU_LATENCY = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic [MDU_CNT_W-1:0] cnt
);

    localparam logic [MDU_CNT_W-1:0] LOAD_VAL = MDU_CNT_W'(MDU_LATENCY);

    logic [MDU_CNT_W-1:0] mdu_cnt_q;
    logic [MDU_CNT_W-1:0] mdu_cnt_d;

    // A start while busy reloads; the ID-stage interlock is what keeps that from happening.
    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (start) begin
            mdu_cnt_d = LOAD_VAL;
        end else if (mdu_cnt_q != '0) begin
            mdu_cnt_d = mdu_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            mdu_cnt_q <= '0;
        end else begin
            mdu_cnt_q <= mdu_cnt_d;
        end
    end

    assign busy = (mdu_cnt_q != '0);
    assign cnt  = mdu_cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline interlock: load-use and MDU stalls, taken-branch flush; drives PC, IF/ID and ID/EX controls.
// Controls are combinational (same-cycle stall); optional stall counter enabled by HAZARD_PERF_EN.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MDU_LATENCY = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [REG_W-1:0]       id_rs,
    input  logic [REG_W-1:0]       id_rt,
    input  logic                   id_uses_rt,
    input  logic                   id_hilo_rd,
    input  logic                   id_mdu_op,
    input  logic [REG_W-1:0]       ex_rt,
    input  logic                   ex_memread,
    input  logic                   ex_mdu_start,
    input  logic                   ex_branch_tkn,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   mdu_busy,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic                 load_use;
    logic                 mdu_use;
    logic                 stall;
    logic [MDU_CNT_W-1:0] mdu_cnt;
    hz_cause_e            cause;

    // A taken branch squashes ID/IF but never the MDU op already issued from EX.
    mdu_timer #(
        .MDU_LATENCY (MDU_LATENCY)
    ) u_mdu_timer (
        .clock (clock),
        .reset (reset),
        .start (ex_mdu_start),
        .busy  (mdu_busy),
        .cnt   (mdu_cnt)
    );

    assign load_use = load_use_hit(ex_memread, ex_rt, id_rs, id_rt, id_uses_rt);
    assign mdu_use  = mdu_busy && (id_hilo_rd || id_mdu_op);

    always_comb begin
        cause = HZ_NONE;
        if (ex_branch_tkn) begin
            cause = HZ_BRANCH;
        end else if (load_use) begin
            cause = HZ_LOADUSE;
        end else if (mdu_use) begin
            cause = HZ_MDU;
        end
    end

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        stall      = 1'b0;
        unique case (cause)
            HZ_BRANCH: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            HZ_LOADUSE, HZ_MDU: begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
                stall      = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef HAZARD_PERF_EN
    logic [STALL_CNT_W-1:0] stall_count_q;
    logic [STALL_CNT_W-1:0] stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = '0;
`endif

    logic unused_ok;
    assign unused_ok = ^{mdu_cnt, stall};

endmodule
